id_ex_pipeline_reg: RTL and testbench
=====================================

// Module: id_ex_pipeline_reg
// PURPOSE
//  ID/EX pipeline register of the pipelined RISC-V core. Captures decoded control, operands,
//  immediate and register indices from ID each cycle and presents them to EX.
//  Supplies ex_alu_op/ex_funct to ALU_Control and operands to the ALU and forwarding unit.
//  Supports hold (stall) and bubble (flush) insertion from the hazard/branch logic.
// PARAMETERS
//  XLEN        64  datapath width: PC, register operands, immediate
//  REG_ADDR_W  5   register index width
// PORTS
//  clk           in   1          single clock; all state updates on rising edge
//  reset         in   1          synchronous, active-low; sampled on rising clk edge
//  id_valid      in   1          ID stage holds a real instruction
//  id_reg_write  in   1          control: write register file in WB
//  id_mem_to_reg in   1          control: WB selects memory data
//  id_mem_read   in   1          control: load
//  id_mem_write  in   1          control: store
//  id_branch     in   1          control: conditional branch
//  id_alu_src    in   1          control: ALU operand B = immediate
//  id_alu_op     in   2          control: 00 add, 01 sub/branch, 10 R-type decode
//  id_funct      in   4          {instr[30], instr[14:12]}
//  id_pc         in   XLEN       instruction PC
//  id_rs1_data   in   XLEN       register file read data 1
//  id_rs2_data   in   XLEN       register file read data 2
//  id_imm        in   XLEN       sign-extended immediate
//  id_rs1/id_rs2/id_rd in REG_ADDR_W  source/destination indices
//  hold          in   1          keep all outputs unchanged this edge
//  flush         in   1          insert bubble this edge
//  ex_*          out  (same)     registered copy of each id_* input, incl. ex_valid
// BEHAVIOUR
//  - Latency: exactly 1 cycle; an input sampled at edge N appears on ex_* after edge N.
//  - Priority per rising edge: reset low > flush > hold > load.
//  - Reset (reset==0): every ex_* output = 0, which equals a bubble (no side effects).
//  - flush==1: ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch,
//    ex_alu_src = 0; ex_alu_op = 2'b00; ex_funct = 0; all data/index fields = 0.
//    Flush wins over a simultaneous hold.
//  - hold==1 (flush==0): all ex_* keep their previous values; ID inputs are ignored.
//  - Load (hold==0, flush==0): all ex_* <= id_*. If id_valid==0, the control fields are
//    forced to 0 (bubble); data fields still load.
//  - Invariant: ex_valid==0 implies ex_reg_write==ex_mem_read==ex_mem_write==ex_branch==0.
//  - Reset asserted mid-hold or mid-flush: the reset value is taken on that edge; the next
//    edge with reset high performs a normal load.
//  - No combinational path from any input to any output.
//  - No arithmetic is performed; widths pass through unchanged.
// STRUCTURE
//  - Shared package core_pkg: XLEN, REG_ADDR_W; ALU_OP_ADD=2'b00, ALU_OP_SUB=2'b01,
//    ALU_OP_RTYPE=2'b10; funct codes ADD=4'b0000, SUB=4'b1000, AND=4'b0111, OR=4'b0110.
//    Typedef ctrl_t packs the 7 control fields plus valid.
//  - One natural sub-module: pipe_field_reg #(W): a W-bit register with
//    sync active-low reset, clear (flush) and enable (~hold).
//    Instantiated once for ctrl_t and once per data field.
// TESTING
//  1. reset=0 for 2 cycles with id_* all ones -> every ex_* == 0.
//  2. Load add x3,x1,x2 (alu_op=10, funct=0000, rs1_data=5, rs2_data=7, rd=3, reg_write=1)
//     -> next cycle ex_funct=0000, ex_rs1_data=5, ex_rd=3, ex_valid=1.
//  3. Load sub (funct=1000), then hold=1 for 3 cycles while ID changes to an and
//     (funct=0111) -> ex_funct stays 1000 through the hold; becomes 0111 the cycle
//     after hold drops.
//  4. Load sd (mem_write=1) with flush=1 and hold=1 on the same edge -> ex_mem_write=0,
//     ex_valid=0, ex_alu_op=00.
//  5. id_valid=0 with id_reg_write=1, id_rd=5 -> ex_reg_write=0, ex_valid=0, ex_rd=5.
//  6. Back-to-back stream of 8 instructions with random hold/flush; scoreboard vs reference
//     model checks the priority order and the ex_valid invariant every cycle.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, ALU op / funct encodings and the
// packed control bundle carried between pipeline stages.
package core_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 2;
  localparam int unsigned FUNCT_W    = 4;

  localparam logic [ALU_OP_W-1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [ALU_OP_W-1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [ALU_OP_W-1:0] ALU_OP_RTYPE = 2'b10;

  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'b0000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'b1000;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'b0111;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 4'b0110;

  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/pipe_field_reg.sv
// One pipeline field: W-bit register with sync active-low reset, clear
// (bubble insertion) and enable (cleared by a stall).
module pipe_field_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Priority: reset > clear > enable.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: one-cycle registered hand-off of decoded control,
// operands, immediate and register indices, with stall hold and flush bubbles.
module id_ex_pipeline_reg
  import core_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic                  id_reg_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_branch,
  input  logic                  id_alu_src,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [FUNCT_W-1:0]    id_funct,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_alu_src,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [FUNCT_W-1:0]    ex_funct,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;
  logic  en;

  assign en = ~hold;

  // An invalid ID slot enters EX as a bubble so it can have no side effects.
  always_comb begin
    ctrl_d = '0;
    if (id_valid) begin
      ctrl_d.valid      = 1'b1;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.branch     = id_branch;
      ctrl_d.alu_src    = id_alu_src;
      ctrl_d.alu_op     = id_alu_op;
    end
  end

  pipe_field_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(ctrl_d), .q(ctrl_q)
  );

  pipe_field_reg #(.W(FUNCT_W)) u_funct (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_funct), .q(ex_funct)
  );

  pipe_field_reg #(.W(XLEN)) u_pc (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_pc), .q(ex_pc)
  );

  pipe_field_reg #(.W(XLEN)) u_rs1_data (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_rs1_data), .q(ex_rs1_data)
  );

  pipe_field_reg #(.W(XLEN)) u_rs2_data (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_rs2_data), .q(ex_rs2_data)
  );

  pipe_field_reg #(.W(XLEN)) u_imm (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_imm), .q(ex_imm)
  );

  pipe_field_reg #(.W(REG_ADDR_W)) u_rs1 (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_rs1), .q(ex_rs1)
  );

  pipe_field_reg #(.W(REG_ADDR_W)) u_rs2 (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_rs2), .q(ex_rs2)
  );

  pipe_field_reg #(.W(REG_ADDR_W)) u_rd (
    .clk(clk), .reset(reset), .clear(flush), .en(en), .d(id_rd), .q(ex_rd)
  );

  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Scoreboard bench for id_ex_pipeline_reg: the driver queues the expected EX
// view for each edge, the monitor pops and compares after that edge.
module tb_id_ex_pipeline_reg;
  import core_pkg::*;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  alu_src;
    logic [1:0]            alu_op;
    logic [3:0]            funct;
    logic [XLEN-1:0]       pc;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } out_t;

  logic clk = 1'b0;
  logic reset, hold, flush;
  logic id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_alu_src;
  logic [1:0] id_alu_op;
  logic [3:0] id_funct;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_ADDR_W-1:0] id_rs1, id_rs2, id_rd;
  logic ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [3:0] ex_funct;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_ADDR_W-1:0] ex_rs1, ex_rs2, ex_rd;

  out_t  exp_q[$];
  out_t  mask_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  out_t  model;
  out_t  full_mask;

  always #5 clk = ~clk;

  id_ex_pipeline_reg dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_branch(id_branch),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .hold(hold), .flush(flush),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_funct(ex_funct),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd)
  );

  function automatic out_t mk(input logic v, rw, m2r, mr, mw, br, as,
                              input logic [1:0] aop, input logic [3:0] fn,
                              input logic [XLEN-1:0] pc, r1d, r2d, imm,
                              input logic [REG_ADDR_W-1:0] r1, r2, rd);
    out_t o;
    o = '{valid: v, reg_write: rw, mem_to_reg: m2r, mem_read: mr, mem_write: mw,
          branch: br, alu_src: as, alu_op: aop, funct: fn, pc: pc, rs1_data: r1d,
          rs2_data: r2d, imm: imm, rs1: r1, rs2: r2, rd: rd};
    return o;
  endfunction

  task automatic drive(input logic v, rw, m2r, mr, mw, br, as,
                       input logic [1:0] aop, input logic [3:0] fn,
                       input logic [XLEN-1:0] pc, r1d, r2d, imm,
                       input logic [REG_ADDR_W-1:0] r1, r2, rd);
    id_valid = v; id_reg_write = rw; id_mem_to_reg = m2r; id_mem_read = mr;
    id_mem_write = mw; id_branch = br; id_alu_src = as; id_alu_op = aop;
    id_funct = fn; id_pc = pc; id_rs1_data = r1d; id_rs2_data = r2d; id_imm = imm;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
  endtask

  // Queue the expectation for the coming edge, then advance past it.
  task automatic step(input string name, input out_t exp, input out_t mask);
    exp_q.push_back(exp);
    mask_q.push_back(mask);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  // Spec-level reference for the random stream.
  task automatic model_step();
    if (!reset || flush) begin
      model = '0;
    end else if (!hold) begin
      model = mk(id_valid, id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write,
                 id_branch, id_alu_src, id_alu_op, id_funct, id_pc, id_rs1_data,
                 id_rs2_data, id_imm, id_rs1, id_rs2, id_rd);
      if (!id_valid) begin
        {model.valid, model.reg_write, model.mem_to_reg, model.mem_read,
         model.mem_write, model.branch, model.alu_src, model.alu_op} = '0;
      end
    end
  endtask

  // Monitor: compare after every edge that has a queued expectation.
  always @(negedge clk) begin
    out_t act, exp, mask;
    string name;
    if (exp_q.size() > 0) begin
      exp  = exp_q.pop_front();
      mask = mask_q.pop_front();
      name = name_q.pop_front();
      act = {ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch,
             ex_alu_src, ex_alu_op, ex_funct, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd};
      checks++;
      if (((act ^ exp) & mask) != '0) begin
        errors++;
        $display("FAIL %s: got %h expected %h (mask %h)", name, act, exp, mask);
      end
      checks++;
      if (!ex_valid && (ex_reg_write || ex_mem_read || ex_mem_write || ex_branch)) begin
        errors++;
        $display("FAIL invariant(%s): got rw=%b mr=%b mw=%b br=%b expected 0 with ex_valid=0",
                 name, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch);
      end
    end
  end

  initial begin
    out_t ones, sub_e, and_e, e, fmask;
    int wait_cycles;
    fmask = '1;
    full_mask = fmask;
    ones = '1;

    // Reset with every ID input at ones.
    reset = 1'b0; hold = 1'b0; flush = 1'b0;
    drive(1, 1, 1, 1, 1, 1, 1, 2'b11, 4'hF, '1, '1, '1, '1, '1, '1, '1);
    step("reset0", '0, fmask);
    step("reset1", '0, fmask);

    // add x3,x1,x2
    reset = 1'b1;
    drive(1, 1, 0, 0, 0, 0, 0, ALU_OP_RTYPE, FUNCT_ADD, 64'h100, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd3);
    e = mk(1, 1, 0, 0, 0, 0, 0, 2'b10, 4'b0000, 64'h100, 64'd5, 64'd7, 64'd0, 5'd1, 5'd2, 5'd3);
    step("add", e, fmask);

    // sub, then hold 3 cycles while ID shows an and
    drive(1, 1, 0, 0, 0, 0, 0, ALU_OP_RTYPE, FUNCT_SUB, 64'h104, 64'd9, 64'd4, 64'd0, 5'd4, 5'd5, 5'd6);
    sub_e = mk(1, 1, 0, 0, 0, 0, 0, 2'b10, 4'b1000, 64'h104, 64'd9, 64'd4, 64'd0, 5'd4, 5'd5, 5'd6);
    step("sub", sub_e, fmask);
    drive(1, 1, 0, 0, 0, 0, 0, ALU_OP_RTYPE, FUNCT_AND, 64'h108, 64'd12, 64'd10, 64'd0, 5'd6, 5'd4, 5'd7);
    and_e = mk(1, 1, 0, 0, 0, 0, 0, 2'b10, 4'b0111, 64'h108, 64'd12, 64'd10, 64'd0, 5'd6, 5'd4, 5'd7);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step("hold_sub", sub_e, fmask);
    hold = 1'b0;
    step("and_after_hold", and_e, fmask);

    // sd with flush and hold together: bubble
    flush = 1'b1; hold = 1'b1;
    drive(1, 0, 0, 0, 1, 0, 1, ALU_OP_ADD, 4'b0011, 64'h10C, 64'd40, 64'd99, 64'd8, 5'd2, 5'd9, 5'd0);
    step("flush_over_hold", '0, fmask);
    flush = 1'b0; hold = 1'b0;

    // invalid slot: control forced off, data still loads
    drive(0, 1, 0, 0, 0, 0, 0, ALU_OP_RTYPE, 4'b0110, 64'h110, 64'h33, 64'h44, 64'h55, 5'd8, 5'd9, 5'd5);
    e = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0110, 64'h110, 64'h33, 64'h44, 64'h55, 5'd8, 5'd9, 5'd5);
    step("invalid_bubble", e, fmask);

    // reset during hold, then a normal load
    drive(1, 0, 1, 1, 0, 0, 1, ALU_OP_ADD, 4'b0011, 64'h114, 64'h20, 64'h0, 64'h18, 5'd10, 5'd0, 5'd11);
    e = mk(1, 0, 1, 1, 0, 0, 1, 2'b00, 4'b0011, 64'h114, 64'h20, 64'h0, 64'h18, 5'd10, 5'd0, 5'd11);
    step("load_ld", e, fmask);
    hold = 1'b1; reset = 1'b0;
    step("reset_mid_hold", '0, fmask);
    hold = 1'b0; reset = 1'b1;
    step("load_after_reset", e, fmask);
    // reset during flush
    flush = 1'b1; reset = 1'b0;
    step("reset_mid_flush", '0, fmask);
    flush = 1'b0; reset = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 0, ALU_OP_SUB, 4'b0001, 64'h118, 64'h7, 64'h8, 64'hFFFF_FFFF_FFFF_FFF0,
          5'd12, 5'd13, 5'd0);
    e = mk(1, 0, 0, 0, 0, 1, 0, 2'b01, 4'b0001, 64'h118, 64'h7, 64'h8, 64'hFFFF_FFFF_FFFF_FFF0,
           5'd12, 5'd13, 5'd0);
    step("branch_load", e, fmask);

    // Random stream of 8 instructions (plus stalls) from a known state.
    reset = 1'b0;
    model = '0;
    step("stream_reset", '0, fmask);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 4'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom));
      hold  = 1'($urandom_range(0, 2) == 0);
      flush = 1'($urandom_range(0, 4) == 0);
      model_step();
      step("stream", model, full_mask);
      while (hold && !flush) begin
        hold = 1'($urandom_range(0, 1) == 0);
        model_step();
        step("stream_stall", model, full_mask);
      end
    end
    hold = 1'b0; flush = 1'b0;

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    if (ones == '0) $display("unreachable");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
